// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the ram4096 two-port arbiter.
package ram_arb_pkg;

  localparam int AW = 12;
  localparam int DW = 16;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/ram4096_arbiter_if.sv
// One requester's four-phase req/ack port onto the shared RAM.
interface ram4096_arbiter_if;
  import ram_arb_pkg::*;

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/ram_rr_pick2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to whoever was not served last.
module ram_rr_pick2
  import ram_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic valid,
  output logic sel
);

  assign valid = req_a | req_b;
  assign sel   = (req_a && req_b) ? ~last : (req_b ? REQ_B : REQ_A);

endmodule

// File: rtl/ram4096_arbiter.sv
// Shares one ram4096 between requesters A and B with round-robin four-phase handshakes,
// optionally sweeping the whole RAM to INIT_VALUE after reset.
module ram4096_arbiter
  import ram_arb_pkg::*;
#(
  parameter bit            CLEAR_ON_RESET = 1'b1,
  parameter logic [DW-1:0] INIT_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset,
  ram4096_arbiter_if.slave a,
  ram4096_arbiter_if.slave b,
  output logic [AW-1:0]    ram_address,
  output logic [DW-1:0]    ram_in,
  output logic             ram_load,
  input  logic [DW-1:0]    ram_out,
  output logic             busy
);

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;
  logic          sel_q;
  logic          last_q;
  logic          a_ack_q;
  logic          b_ack_q;
  logic [DW-1:0] a_rdata_q;
  logic [DW-1:0] b_rdata_q;

  logic          pick_valid;
  logic          pick_sel;
  logic [DW-1:0] result;
  logic          sel_req;

  ram_rr_pick2 u_pick (
    .req_a (a.req),
    .req_b (b.req),
    .last  (last_q),
    .valid (pick_valid),
    .sel   (pick_sel)
  );

  // A write reports the data it stored, so both cases return through the same register.
  assign result  = we_q ? wdata_q : ram_out;
  assign sel_req = (sel_q == REQ_B) ? b.req : a.req;

  // NOTE: non-blocking assignments so every register here samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_cnt   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      sel_q     <= REQ_A;
      last_q    <= REQ_B;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          if (clr_cnt == {AW{1'b1}}) state <= IDLE;
          else                       clr_cnt <= clr_cnt + AW'(1);
        end
        IDLE: begin
          if (pick_valid) begin
            sel_q   <= pick_sel;
            we_q    <= pick_sel ? b.we    : a.we;
            addr_q  <= pick_sel ? b.addr  : a.addr;
            wdata_q <= pick_sel ? b.wdata : a.wdata;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (sel_q == REQ_B) begin
            b_rdata_q <= result;
            b_ack_q   <= 1'b1;
          end else begin
            a_rdata_q <= result;
            a_ack_q   <= 1'b1;
          end
          last_q <= sel_q;
          state  <= DONE;
        end
        DONE: begin
          if (!sel_req) begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gating load with reset keeps a write in flight from landing on the reset edge.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    ram_address = addr_q;
    ram_in      = wdata_q;
    ram_load    = 1'b0;
    unique case (state)
      CLEAR: begin
        ram_address = clr_cnt;
        ram_in      = INIT_VALUE;
        ram_load    = ~reset;
      end
      ACCESS:  ram_load = we_q & ~reset;
      default: ram_load = 1'b0;
    endcase
  end

  assign busy    = (state == CLEAR);
  assign a.ack   = a_ack_q;
  assign b.ack   = b_ack_q;
  assign a.rdata = a_rdata_q;
  assign b.rdata = b_rdata_q;

endmodule
